// File: rtl/mem_lsu_if.sv
// Data-memory port of the load/store stage: request/grant/response handshake.
// Signal names are seen from the LSU side; the memory uses the slave modport.
interface mem_lsu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  dmem_req_o;
    logic                  dmem_we_o;
    logic [DATA_W/8-1:0]   dmem_be_o;
    logic [ADDR_W-1:0]     dmem_addr_o;
    logic [DATA_W-1:0]     dmem_wdata_o;
    logic                  dmem_gnt_i;
    logic                  dmem_rvalid_i;
    logic [DATA_W-1:0]     dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores on the data-memory port, aligns and
// extends load data, stalls while an access is pending, registers the write-back.
module mem_lsu #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_W-1:0]     reg_wdata_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [2:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    mem_lsu_if.master             dmem,
    output logic                  stall_req_o,
    output logic                  misalign_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_W-1:0]     reg_wdata_o
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic {IDLE, WAIT_R} state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [REG_ADDR_W-1:0] ld_waddr_q, ld_waddr_d;
    logic                  ld_we_q, ld_we_d;
    logic [REG_ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic                  reg_we_q, reg_we_d;
    logic [DATA_W-1:0]     reg_wdata_q, reg_wdata_d;
    logic                  misalign_q, misalign_d;

    logic [OFF_W-1:0]  off;
    logic [1:0]        sz_log2;
    logic              is_mem, illegal, misaligned, bad;
    logic [7:0]        be_mask;
    logic [NB-1:0]     be_c;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] ld_data;
    logic              req_c, we_c, stall_c;

    assign off     = mem_addr_i[OFF_W-1:0];
    assign sz_log2 = mem_op_i[1:0];
    assign is_mem  = mem_re_i | mem_we_i;

    // Access legality and size-dependent byte mask / store-data replication
    always_comb begin
        illegal = (mem_op_i == 3'b111) ||
                  ((DATA_W == 32) && ((mem_op_i == 3'b011) || (mem_op_i == 3'b110)));
        case (sz_log2)
            2'd0: begin
                misaligned = 1'b0;
                be_mask    = 8'h01;
                wdata_rep  = {NB{mem_wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = mem_addr_i[0];
                be_mask    = 8'h03;
                wdata_rep  = {(NB/2){mem_wdata_i[15:0]}};
            end
            2'd2: begin
                misaligned = |mem_addr_i[1:0];
                be_mask    = 8'h0F;
                wdata_rep  = {(NB/4){mem_wdata_i[31:0]}};
            end
            default: begin
                misaligned = |mem_addr_i[2:0];
                be_mask    = 8'hFF;
                wdata_rep  = mem_wdata_i;
            end
        endcase
        bad  = illegal | misaligned;
        be_c = NB'(be_mask) << off;
    end

    // Load lane extraction uses the op and offset captured at grant
    always_comb begin
        lane = dmem.dmem_rdata_i >> {off_q, 3'b000};
        case (op_q)
            3'b000:  ld_data = DATA_W'($signed(lane[7:0]));
            3'b001:  ld_data = DATA_W'($signed(lane[15:0]));
            3'b010:  ld_data = DATA_W'($signed(lane[31:0]));
            3'b100:  ld_data = DATA_W'(lane[7:0]);
            3'b101:  ld_data = DATA_W'(lane[15:0]);
            3'b110:  ld_data = DATA_W'(lane[31:0]);
            default: ld_data = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        ld_waddr_d  = ld_waddr_q;
        ld_we_d     = ld_we_q;
        reg_waddr_d = reg_waddr_q;
        reg_we_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        misalign_d  = 1'b0;
        req_c       = 1'b0;
        we_c        = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!is_mem) begin
                        reg_waddr_d = reg_waddr_i;
                        reg_we_d    = reg_we_i;
                        reg_wdata_d = reg_wdata_i;
                    end else if (bad) begin
                        misalign_d = 1'b1;
                    end else if (mem_re_i) begin
                        req_c   = 1'b1;
                        stall_c = 1'b1;
                        if (dmem.dmem_gnt_i) begin
                            state_d    = WAIT_R;
                            op_d       = mem_op_i;
                            off_d      = off;
                            ld_waddr_d = reg_waddr_i;
                            ld_we_d    = reg_we_i;
                        end
                    end else begin
                        req_c   = 1'b1;
                        we_c    = 1'b1;
                        stall_c = !dmem.dmem_gnt_i;
                    end
                end
            end
            WAIT_R: begin
                stall_c = !dmem.dmem_rvalid_i;
                if (dmem.dmem_rvalid_i) begin
                    state_d     = IDLE;
                    reg_waddr_d = ld_waddr_q;
                    reg_we_d    = ld_we_q;
                    reg_wdata_d = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            off_q       <= '0;
            ld_waddr_q  <= '0;
            ld_we_q     <= 1'b0;
            reg_waddr_q <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            ld_waddr_q  <= ld_waddr_d;
            ld_we_q     <= ld_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign dmem.dmem_req_o   = req_c;
    assign dmem.dmem_we_o    = we_c;
    assign dmem.dmem_be_o    = req_c ? be_c : '0;
    assign dmem.dmem_addr_o  = {mem_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign dmem.dmem_wdata_o = wdata_rep;
    assign stall_req_o       = stall_c;
    assign misalign_o        = misalign_q;
    assign reg_waddr_o       = reg_waddr_q;
    assign reg_we_o          = reg_we_q;
    assign reg_wdata_o       = reg_wdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: 32- and 64-bit instances, directed cases then random
// transactions checked against a transaction-level reference model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, reg_we_i, mem_re_i, mem_we_i;
    logic [4:0]  reg_waddr_i;
    logic [63:0] reg_wdata_i, mem_wdata_i, rdata;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic        gnt, rvalid;
    bit          w64;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    assign bus32.dmem_gnt_i    = gnt;
    assign bus32.dmem_rvalid_i = rvalid;
    assign bus32.dmem_rdata_i  = rdata[31:0];
    assign bus64.dmem_gnt_i    = gnt;
    assign bus64.dmem_rvalid_i = rvalid;
    assign bus64.dmem_rdata_i  = rdata;

    logic        stall32, mis32, rwe32, stall64, mis64, rwe64;
    logic [4:0]  rwa32, rwa64;
    logic [31:0] rwd32;
    logic [63:0] rwd64;

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut32 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .reg_waddr_i(reg_waddr_i),
        .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i[31:0]), .mem_re_i(mem_re_i),
        .mem_we_i(mem_we_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i[31:0]), .dmem(bus32.master), .stall_req_o(stall32),
        .misalign_o(mis32), .reg_waddr_o(rwa32), .reg_we_o(rwe32), .reg_wdata_o(rwd32)
    );

    mem_lsu #(.DATA_W(64), .ADDR_W(32), .REG_ADDR_W(5)) dut64 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .reg_waddr_i(reg_waddr_i),
        .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .mem_re_i(mem_re_i),
        .mem_we_i(mem_we_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .dmem(bus64.master), .stall_req_o(stall64),
        .misalign_o(mis64), .reg_waddr_o(rwa64), .reg_we_o(rwe64), .reg_wdata_o(rwd64)
    );

    // Observed outputs of whichever instance is under test
    logic        o_req, o_we, o_stall, o_mis, o_rwe;
    logic [7:0]  o_be;
    logic [31:0] o_addr;
    logic [63:0] o_wdata, o_rwdata;
    logic [4:0]  o_rwaddr;
    always_comb begin
        if (w64) begin
            o_req = bus64.dmem_req_o;  o_we = bus64.dmem_we_o;  o_be = bus64.dmem_be_o;
            o_addr = bus64.dmem_addr_o; o_wdata = bus64.dmem_wdata_o;
            o_stall = stall64; o_mis = mis64; o_rwe = rwe64; o_rwaddr = rwa64; o_rwdata = rwd64;
        end else begin
            o_req = bus32.dmem_req_o;  o_we = bus32.dmem_we_o;  o_be = {4'b0, bus32.dmem_be_o};
            o_addr = bus32.dmem_addr_o; o_wdata = {32'b0, bus32.dmem_wdata_o};
            o_stall = stall32; o_mis = mis32; o_rwe = rwe32; o_rwaddr = rwa32;
            o_rwdata = {32'b0, rwd32};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes();
        return w64 ? 8 : 4;
    endfunction

    function automatic int opsize(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    function automatic logic [63:0] lmask(input int sz);
        return (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    endfunction

    function automatic bit op_bad(input logic [2:0] op, input logic [31:0] a);
        if (op == 3'd7) return 1'b1;
        if (!w64 && (op == 3'd3 || op == 3'd6)) return 1'b1;
        return (a % 32'(opsize(op))) != 0;
    endfunction

    function automatic logic [63:0] exp_be(input logic [2:0] op, input logic [31:0] a);
        return ((64'd1 << opsize(op)) - 64'd1) << (a % 32'(nbytes()));
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [2:0] op, input logic [63:0] wd);
        logic [63:0] r = '0;
        int sz = opsize(op);
        for (int i = 0; i < nbytes(); i += sz) r |= (wd & lmask(sz)) << (8 * i);
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [63:0] rd);
        int          sz  = opsize(op);
        int          off = int'(a % 32'(nbytes()));
        logic [63:0] v   = (rd >> (8 * off)) & lmask(sz);
        if (op < 3'd4 && v[8*sz-1]) v |= ~lmask(sz);
        if (!w64) v &= 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] trunc(input logic [63:0] x);
        return w64 ? x : {32'b0, x[31:0]};
    endfunction

    // One instruction from presentation to write-back; g = grant wait cycles, r = rvalid delay after grant
    task automatic txn(input logic v, input logic re, input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [63:0] wd, input logic [4:0] wa,
                       input logic rwe, input logic [63:0] rwd, input int g, input int r,
                       input logic [63:0] rd);
        bit mem = v && (re || we);
        bit bad = mem && op_bad(op, a);
        bit ld  = mem && !bad && re;
        bit st  = mem && !bad && !re;
        bit alu = v && !mem;
        int nb  = nbytes();
        @(negedge clk);
        valid_i = v; mem_re_i = re; mem_we_i = we; mem_op_i = op; mem_addr_i = a;
        mem_wdata_i = wd; reg_waddr_i = wa; reg_we_i = rwe; reg_wdata_i = rwd;
        if (ld || st) begin
            for (int c = 0; c <= g; c++) begin
                if (c > 0) @(negedge clk);
                gnt = (c == g); rvalid = 1'($urandom); rdata = {$urandom, $urandom};
                #1;
                chk("req", 64'(o_req), 64'd1);
                chk("we", 64'(o_we), 64'(st));
                chk("be", 64'(o_be), exp_be(op, a));
                chk("addr", 64'(o_addr), 64'(a - (a % 32'(nb))));
                if (st) chk("wdata", o_wdata, exp_wdata(op, wd));
                chk("stall_req", 64'(o_stall), 64'(ld || (c != g)));
                @(posedge clk); #1;
                chk("reg_we_req", 64'(o_rwe), 64'd0);
                chk("misalign_req", 64'(o_mis), 64'd0);
            end
            if (ld) begin
                for (int k = 1; k <= r; k++) begin
                    @(negedge clk);
                    gnt = 1'($urandom); rvalid = (k == r);
                    rdata = (k == r) ? rd : {$urandom, $urandom};
                    #1;
                    chk("req_wait", 64'(o_req), 64'd0);
                    chk("stall_wait", 64'(o_stall), 64'(k != r));
                    @(posedge clk); #1;
                    chk("reg_we_wait", 64'(o_rwe), (k == r) ? 64'(rwe) : 64'd0);
                    chk("misalign_wait", 64'(o_mis), 64'd0);
                    if (k == r) begin
                        chk("ld_waddr", 64'(o_rwaddr), 64'(wa));
                        chk("ld_wdata", o_rwdata, exp_load(op, a, rd));
                    end
                end
            end
        end else begin
            gnt = 1'($urandom); rvalid = 1'($urandom); rdata = {$urandom, $urandom};
            #1;
            chk("req_none", 64'(o_req), 64'd0);
            chk("stall_none", 64'(o_stall), 64'd0);
            @(posedge clk); #1;
            chk("reg_we", 64'(o_rwe), alu ? 64'(rwe) : 64'd0);
            chk("misalign", 64'(o_mis), 64'(bad));
            if (alu) begin
                chk("alu_waddr", 64'(o_rwaddr), 64'(wa));
                chk("alu_wdata", o_rwdata, trunc(rwd));
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        valid_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rv, rre, rwe_r, rregwe;
        logic [2:0]  rop;
        logic [31:0] ra;
        int          sz;
        rst = 1'b1; w64 = 1'b0;
        valid_i = 0; reg_we_i = 0; mem_re_i = 0; mem_we_i = 0; reg_waddr_i = '0;
        reg_wdata_i = '0; mem_wdata_i = '0; mem_op_i = '0; mem_addr_i = '0;
        gnt = 0; rvalid = 0; rdata = '0;
        #12;
        chk("rst_req", 64'(o_req), 64'd0);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_be", 64'(o_be), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);
        chk("rst_misalign", 64'(o_mis), 64'd0);
        chk("rst_reg_we", 64'(o_rwe), 64'd0);
        chk("rst_reg_waddr", 64'(o_rwaddr), 64'd0);
        chk("rst_reg_wdata", o_rwdata, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases, 32-bit instance
        txn(1, 0, 0, 3'd0, 32'h0, 64'h0, 5'd5, 1, 64'h1234, 0, 0, 64'h0);
        chk("alu_const", o_rwdata, 64'h1234);
        txn(1, 1, 0, 3'd0, 32'h102, 64'h0, 5'd3, 1, 64'h0, 0, 1, 64'h80FF_0000);
        chk("lb_const", o_rwdata, 64'hFFFF_FFFF);
        txn(1, 1, 0, 3'd4, 32'h102, 64'h0, 5'd3, 1, 64'h0, 0, 1, 64'h80FF_0000);
        chk("lbu_const", o_rwdata, 64'h0000_00FF);
        txn(1, 0, 1, 3'd1, 32'h2, 64'hABCD, 5'd7, 1, 64'h0, 3, 0, 64'h0);
        txn(1, 1, 0, 3'd2, 32'h6, 64'h0, 5'd9, 1, 64'h0, 0, 1, 64'h0);
        txn(0, 1, 0, 3'd2, 32'h0, 64'h0, 5'd1, 1, 64'h0, 0, 1, 64'h0);
        txn(1, 0, 0, 3'd0, 32'h0, 64'h0, 5'd4, 1, 64'h5A5A, 0, 0, 64'h0);

        // Reset while a load waits for data, then a stale response in IDLE
        @(negedge clk);
        valid_i = 1; mem_re_i = 1; mem_we_i = 0; mem_op_i = 3'd2; mem_addr_i = 32'h40;
        reg_waddr_i = 5'd8; reg_we_i = 1; gnt = 1; rvalid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        valid_i = 0; mem_re_i = 0; gnt = 0; rst = 1'b1;
        #1;
        chk("rstw_req", 64'(o_req), 64'd0);
        chk("rstw_we", 64'(o_we), 64'd0);
        chk("rstw_be", 64'(o_be), 64'd0);
        chk("rstw_stall", 64'(o_stall), 64'd0);
        chk("rstw_misalign", 64'(o_mis), 64'd0);
        chk("rstw_reg_we", 64'(o_rwe), 64'd0);
        chk("rstw_reg_wdata", o_rwdata, 64'd0);
        @(negedge clk);
        rst = 1'b0; rvalid = 1; rdata = 64'hDEAD_BEEF;
        #1;
        chk("stale_stall", 64'(o_stall), 64'd0);
        chk("stale_req", 64'(o_req), 64'd0);
        @(posedge clk); #1;
        chk("stale_reg_we", 64'(o_rwe), 64'd0);
        chk("stale_reg_wdata", o_rwdata, 64'd0);

        // Random traffic on both widths
        for (int pass = 0; pass < 2; pass++) begin
            w64 = (pass == 1);
            reset_pulse();
            if (w64) begin
                txn(1, 1, 0, 3'd3, 32'h8, 64'h0, 5'd2, 1, 64'h0, 0, 1, 64'h8000_0000_0000_0001);
                chk("ld64_const", o_rwdata, 64'h8000_0000_0000_0001);
            end
            for (int i = 0; i < 200; i++) begin
                rv = ($urandom_range(0, 7) != 0);
                rre = 1'($urandom); rwe_r = 1'($urandom); rregwe = 1'($urandom);
                if ($urandom_range(0, 3) == 0) begin rre = 1'b0; rwe_r = 1'b0; end
                rop = 3'($urandom_range(0, 7));
                ra = $urandom;
                sz = opsize(rop);
                if ($urandom_range(0, 3) != 0) ra = ra - (ra % 32'(sz));
                txn(rv, rre, rwe_r, rop, ra, {$urandom, $urandom}, 5'($urandom), rregwe,
                    {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 3),
                    {$urandom, $urandom});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
